cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory/write-back
// and counts retired instructions. The state register is clocked; the strobes are decoded from it.
module cpu_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_update,
    output logic        wb_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        halted,
    output logic        err,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    function automatic logic is_alu(input logic [5:0] o);
        return (o[5:4] == 2'b00);
    endfunction

    function automatic logic is_lw(input logic [5:0] o);
        return (o == 6'b010000);
    endfunction

    function automatic logic is_sw(input logic [5:0] o);
        return (o == 6'b010001);
    endfunction

    function automatic logic is_beq(input logic [5:0] o);
        return (o == 6'b100000);
    endfunction

    function automatic logic is_jmp(input logic [5:0] o);
        return (o == 6'b100001);
    endfunction

    state_t          state_q;
    state_t          state_d;
    state_t          boundary;
    logic [5:0]      op_q;
    logic [WW-1:0]   wait_q;
    logic [31:0]     cnt_q;

    // State register and the opcode captured while DECODE is active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= op;
            end
        end
    end

    // MEM wait counter: zero outside MEM, so it is already cleared on MEM entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (state_q == S_MEM && !dmem_ready) begin
            wait_q <= wait_q + WW'(1);
        end else begin
            wait_q <= '0;
        end
    end

    // Retired-instruction counter, wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else if (pc_we) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'b00;
        reg_update = 1'b0;
        wb_sel     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        boundary   = run ? S_FETCH : S_IDLE;
        case (state_q)
            S_IDLE: begin
                state_d = boundary;
            end
            S_FETCH: begin
                ir_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op == 6'b111111) begin
                    state_d = S_HALT;
                end else if (is_alu(op) || is_lw(op) || is_sw(op) || is_beq(op) || is_jmp(op)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_EXEC: begin
                if (is_alu(op_q)) begin
                    state_d = S_WB;
                end else if (is_lw(op_q) || is_sw(op_q)) begin
                    state_d = S_MEM;
                end else if (is_beq(op_q)) begin
                    pc_we   = 1'b1;
                    pc_sel  = zero ? 2'b01 : 2'b00;
                    state_d = boundary;
                end else if (is_jmp(op_q)) begin
                    pc_we   = 1'b1;
                    pc_sel  = 2'b10;
                    state_d = boundary;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw(op_q);
                // A ready on the last allowed cycle wins over the timeout.
                if (dmem_ready) begin
                    if (is_sw(op_q)) begin
                        pc_we   = 1'b1;
                        state_d = boundary;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                reg_update = 1'b1;
                pc_we      = 1'b1;
                wb_sel     = is_lw(op_q);
                state_d    = boundary;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    assign halted    = (state_q == S_HALT);
    assign err       = (state_q == S_ERR);
    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: each step queues the expected outputs for the
// current state, then pops and compares them shortly after inputs settle.
module tb_cpu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [5:0]  op;
    logic        zero;
    logic        dmem_ready;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        reg_update;
    logic        wb_sel;
    logic        mem_req;
    logic        mem_we;
    logic        halted;
    logic        err;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [12:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    localparam logic [5:0] OP_ALU = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b010000;
    localparam logic [5:0] OP_SW  = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_JMP = 6'b100001;
    localparam logic [5:0] OP_HLT = 6'b111111;
    localparam logic [5:0] OP_BAD = 6'b110000;

    cpu_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .op         (op),
        .zero       (zero),
        .dmem_ready (dmem_ready),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .reg_update (reg_update),
        .wb_sel     (wb_sel),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .halted     (halted),
        .err        (err),
        .state      (state),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, ir_we, pc_we, pc_sel, reg_update, wb_sel, mem_req, mem_we, halted, err}
    function automatic logic [12:0] mk(input logic [2:0] st, input logic ir, input logic pw,
                                       input logic [1:0] ps, input logic ru, input logic wb,
                                       input logic mr, input logic mw);
        return {st, ir, pw, ps, ru, wb, mr, mw, (st == 3'd6), (st == 3'd7)};
    endfunction

    // One cycle: drive inputs, queue expectation, compare, advance to the next falling edge.
    task automatic cyc(input string tag, input logic r, input logic [5:0] o, input logic z,
                       input logic rdy, input logic [12:0] ctl, input logic [31:0] cnt);
        exp_t e;
        logic [12:0] obs;
        run        = r;
        op         = o;
        zero       = z;
        dmem_ready = rdy;
        sb.push_back('{tag, ctl, cnt});
        #1;
        e   = sb.pop_front();
        obs = {state, ir_we, pc_we, pc_sel, reg_update, wb_sel, mem_req, mem_we, halted, err};
        checks++;
        assert (obs === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl got %h want %h", e.tag, obs, e.ctl);
        end
        checks++;
        assert (instr_cnt === e.cnt) else begin
            errors++;
            $error("FAIL %s instr_cnt got %h want %h", e.tag, instr_cnt, e.cnt);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [2:0] I = 3'd0, F = 3'd1, D = 3'd2, E = 3'd3,
                           M = 3'd4, W = 3'd5, H = 3'd6, R = 3'd7;

    initial begin
        rst_n = 1'b0; run = 1'b0; op = 6'd0; zero = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // ALU op, run dropped after FETCH: instruction completes then IDLE
        cyc("rst_idle", 1'b1, OP_ALU, 1'b0, 1'b0, mk(I,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("alu_fetch", 1'b1, OP_ALU, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd0);
        cyc("alu_dec", 1'b0, OP_ALU, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("alu_exec", 1'b0, OP_ALU, 1'b0, 1'b0, mk(E,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("alu_wb", 1'b0, OP_ALU, 1'b0, 1'b0, mk(W,0,1,2'b00,1,0,0,0), 32'd0);
        cyc("alu_idle", 1'b0, OP_ALU, 1'b0, 1'b0, mk(I,0,0,2'b00,0,0,0,0), 32'd1);

        // LW with ready on the fourth MEM cycle
        cyc("lw_idle", 1'b1, OP_LW, 1'b0, 1'b0, mk(I,0,0,2'b00,0,0,0,0), 32'd1);
        cyc("lw_fetch", 1'b1, OP_LW, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd1);
        cyc("lw_dec", 1'b1, OP_LW, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd1);
        cyc("lw_exec", 1'b1, OP_LW, 1'b0, 1'b0, mk(E,0,0,2'b00,0,0,0,0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc("lw_mem_wait", 1'b1, OP_LW, 1'b0, 1'b0, mk(M,0,0,2'b00,0,0,1,0), 32'd1);
        end
        cyc("lw_mem_rdy", 1'b1, OP_LW, 1'b0, 1'b1, mk(M,0,0,2'b00,0,0,1,0), 32'd1);
        cyc("lw_wb", 1'b1, OP_LW, 1'b0, 1'b0, mk(W,0,1,2'b00,1,1,0,0), 32'd1);

        // SW with immediate ready retires in MEM
        cyc("sw_fetch", 1'b1, OP_SW, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd2);
        cyc("sw_dec", 1'b1, OP_SW, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd2);
        cyc("sw_exec", 1'b1, OP_SW, 1'b0, 1'b0, mk(E,0,0,2'b00,0,0,0,0), 32'd2);
        cyc("sw_mem", 1'b1, OP_SW, 1'b0, 1'b1, mk(M,0,1,2'b00,0,0,1,1), 32'd2);

        // BEQ taken, JMP, BEQ not taken
        cyc("beq1_fetch", 1'b1, OP_BEQ, 1'b1, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd3);
        cyc("beq1_dec", 1'b1, OP_BEQ, 1'b1, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd3);
        cyc("beq1_exec", 1'b1, OP_BEQ, 1'b1, 1'b0, mk(E,0,1,2'b01,0,0,0,0), 32'd3);
        cyc("jmp_fetch", 1'b1, OP_JMP, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd4);
        cyc("jmp_dec", 1'b1, OP_JMP, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd4);
        cyc("jmp_exec", 1'b1, OP_JMP, 1'b0, 1'b0, mk(E,0,1,2'b10,0,0,0,0), 32'd4);
        cyc("beq0_fetch", 1'b1, OP_BEQ, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd5);
        cyc("beq0_dec", 1'b1, OP_BEQ, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd5);
        cyc("beq0_exec", 1'b1, OP_BEQ, 1'b0, 1'b0, mk(E,0,1,2'b00,0,0,0,0), 32'd5);

        // LW with ready exactly on MEM cycle 16 completes normally
        cyc("lw16_fetch", 1'b1, OP_LW, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd6);
        cyc("lw16_dec", 1'b1, OP_LW, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd6);
        cyc("lw16_exec", 1'b1, OP_LW, 1'b0, 1'b0, mk(E,0,0,2'b00,0,0,0,0), 32'd6);
        for (int i = 0; i < 15; i++) begin
            cyc("lw16_wait", 1'b1, OP_LW, 1'b0, 1'b0, mk(M,0,0,2'b00,0,0,1,0), 32'd6);
        end
        cyc("lw16_rdy", 1'b1, OP_LW, 1'b0, 1'b1, mk(M,0,0,2'b00,0,0,1,0), 32'd6);
        cyc("lw16_wb", 1'b1, OP_LW, 1'b0, 1'b0, mk(W,0,1,2'b00,1,1,0,0), 32'd6);

        // Reset asserted during MEM clears the counter
        cyc("rstm_fetch", 1'b1, OP_LW, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd7);
        cyc("rstm_dec", 1'b1, OP_LW, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd7);
        cyc("rstm_exec", 1'b1, OP_LW, 1'b0, 1'b0, mk(E,0,0,2'b00,0,0,0,0), 32'd7);
        rst_n = 1'b0;
        cyc("rstm_mem", 1'b1, OP_LW, 1'b0, 1'b0, mk(M,0,0,2'b00,0,0,1,0), 32'd7);
        rst_n = 1'b1;
        cyc("rstm_idle", 1'b0, OP_LW, 1'b0, 1'b0, mk(I,0,0,2'b00,0,0,0,0), 32'd0);

        // SW timeout: 16 MEM cycles without ready lands in ERR
        cyc("to_idle", 1'b1, OP_SW, 1'b0, 1'b0, mk(I,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("to_fetch", 1'b1, OP_SW, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd0);
        cyc("to_dec", 1'b1, OP_SW, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("to_exec", 1'b1, OP_SW, 1'b0, 1'b0, mk(E,0,0,2'b00,0,0,0,0), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cyc("to_wait", 1'b1, OP_SW, 1'b0, 1'b0, mk(M,0,0,2'b00,0,0,1,1), 32'd0);
        end
        cyc("to_err", 1'b1, OP_SW, 1'b0, 1'b1, mk(R,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("to_err_hold", 1'b1, OP_ALU, 1'b0, 1'b1, mk(R,0,0,2'b00,0,0,0,0), 32'd0);
        do_reset();

        // Illegal opcode
        cyc("ill_idle", 1'b1, OP_BAD, 1'b0, 1'b0, mk(I,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("ill_fetch", 1'b1, OP_BAD, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd0);
        cyc("ill_dec", 1'b1, OP_BAD, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("ill_err", 1'b1, OP_ALU, 1'b0, 1'b0, mk(R,0,0,2'b00,0,0,0,0), 32'd0);
        do_reset();

        // HALT is absorbing regardless of run
        cyc("hlt_idle", 1'b1, OP_HLT, 1'b0, 1'b0, mk(I,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("hlt_fetch", 1'b1, OP_HLT, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'd0);
        cyc("hlt_dec", 1'b1, OP_HLT, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("hlt_halt", 1'b0, OP_ALU, 1'b0, 1'b0, mk(H,0,0,2'b00,0,0,0,0), 32'd0);
        cyc("hlt_hold", 1'b1, OP_ALU, 1'b0, 1'b0, mk(H,0,0,2'b00,0,0,0,0), 32'd0);
        do_reset();

        // Counter wrap from all-ones on one retire
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        cyc("wrap_idle", 1'b1, OP_JMP, 1'b0, 1'b0, mk(I,0,0,2'b00,0,0,0,0), 32'hFFFF_FFFF);
        cyc("wrap_fetch", 1'b1, OP_JMP, 1'b0, 1'b0, mk(F,1,0,2'b00,0,0,0,0), 32'hFFFF_FFFF);
        cyc("wrap_dec", 1'b0, OP_JMP, 1'b0, 1'b0, mk(D,0,0,2'b00,0,0,0,0), 32'hFFFF_FFFF);
        cyc("wrap_exec", 1'b0, OP_JMP, 1'b0, 1'b0, mk(E,0,1,2'b10,0,0,0,0), 32'hFFFF_FFFF);
        cyc("wrap_idle2", 1'b0, OP_JMP, 1'b0, 1'b0, mk(I,0,0,2'b00,0,0,0,0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
